// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared widths, write-target selects and commit FSM states for the ppu front end
package ppu_pkg;

  localparam int PPU_SPRITE_W = 29;
  localparam int PPU_OFFSET_W = 12;
  localparam int PPU_CNT_W    = 8;

  localparam logic [1:0] SEL_SPRITE0 = 2'd0;
  localparam logic [1:0] SEL_SPRITE1 = 2'd1;
  localparam logic [1:0] SEL_OFFSET  = 2'd2;
  localparam logic [1:0] SEL_RSVD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, pointer moves to the loser after every grant
module rr_arbiter2 (
  input  logic clock,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  output logic grant0,
  output logic grant1
);

  logic ptr;  // 0 favours req0, 1 favours req1

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && (!valid1 || !ptr)) begin
        grant0 = 1'b1;
      end else if (valid1) begin
        grant1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/ppu_update_ctrl.sv
// rtl/ppu_update_ctrl.sv - shadows sprite/offset writes and commits them atomically at vblank start
module ppu_update_ctrl
  import ppu_pkg::*;
#(
  parameter int SPRITE_W = PPU_SPRITE_W,
  parameter int OFFSET_W = PPU_OFFSET_W,
  parameter int CNT_W    = PPU_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vblank,
  input  logic                  wr_valid0,
  input  logic [1:0]            wr_sel0,
  input  logic [SPRITE_W-1:0]   wr_data0,
  output logic                  wr_ready0,
  input  logic                  wr_valid1,
  input  logic [1:0]            wr_sel1,
  input  logic [SPRITE_W-1:0]   wr_data1,
  output logic                  wr_ready1,
  output logic [2*SPRITE_W-1:0] sprites,
  output logic [OFFSET_W-1:0]   offset_x,
  output logic [OFFSET_W-1:0]   offset_y,
  output logic                  update,
  output logic                  pending,
  output logic                  overwrite,
  output logic                  sel_err,
  output logic [CNT_W-1:0]      frame_cnt
);

  state_t                state, state_next;
  logic                  vblank_d, rise;
  logic                  wr_fire, wr_marks_dirty;
  logic [1:0]            wr_sel;
  logic [SPRITE_W-1:0]   wr_data;
  logic [SPRITE_W-1:0]   shadow_s0, shadow_s1, sprite0_q, sprite1_q;
  logic [OFFSET_W-1:0]   shadow_ox, shadow_oy;
  logic [2:0]            dirty;

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .valid0 (wr_valid0),
    .valid1 (wr_valid1),
    .enable (state != ST_COMMIT),
    .grant0 (wr_ready0),
    .grant1 (wr_ready1)
  );

  assign rise           = vblank & ~vblank_d;
  assign wr_fire        = wr_ready0 | wr_ready1;
  assign wr_sel         = wr_ready1 ? wr_sel1 : wr_sel0;
  assign wr_data        = wr_ready1 ? wr_data1 : wr_data0;
  assign wr_marks_dirty = wr_fire && (wr_sel != SEL_RSVD);
  assign pending        = |dirty;
  assign sprites        = {sprite0_q, sprite1_q};

  // A write landing in the same cycle as the rise must still trigger a commit.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (rise) state_next = (pending || wr_marks_dirty) ? ST_COMMIT : ST_HOLD;
      ST_COMMIT: state_next = ST_HOLD;
      ST_HOLD:   if (!vblank) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vblank_d  <= 1'b0;
      frame_cnt <= '0;
      update    <= 1'b0;
      dirty     <= '0;
      overwrite <= 1'b0;
      sel_err   <= 1'b0;
      shadow_s0 <= '0;
      shadow_s1 <= '0;
      shadow_ox <= '0;
      shadow_oy <= '0;
      sprite0_q <= '0;
      sprite1_q <= '0;
      offset_x  <= '0;
      offset_y  <= '0;
    end else begin
      vblank_d <= vblank;
      update   <= (state == ST_COMMIT);
      if (rise) frame_cnt <= frame_cnt + 1'b1;

      if (state == ST_COMMIT) begin
        if (dirty[0]) sprite0_q <= shadow_s0;
        if (dirty[1]) sprite1_q <= shadow_s1;
        if (dirty[2]) begin
          offset_x <= shadow_ox;
          offset_y <= shadow_oy;
        end
        dirty     <= '0;
        overwrite <= 1'b0;
      end else if (wr_fire) begin
        case (wr_sel)
          SEL_SPRITE0: begin
            shadow_s0 <= wr_data;
            dirty[0]  <= 1'b1;
            if (dirty[0]) overwrite <= 1'b1;
          end
          SEL_SPRITE1: begin
            shadow_s1 <= wr_data;
            dirty[1]  <= 1'b1;
            if (dirty[1]) overwrite <= 1'b1;
          end
          SEL_OFFSET: begin
            shadow_ox <= wr_data[OFFSET_W-1:0];
            shadow_oy <= wr_data[2*OFFSET_W-1:OFFSET_W];
            dirty[2]  <= 1'b1;
            if (dirty[2]) overwrite <= 1'b1;
          end
          default: sel_err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_update_ctrl.sv
// tb/tb_ppu_update_ctrl.sv - directed self-checking bench for ppu_update_ctrl
module tb_ppu_update_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        vblank;
  logic        wr_valid0, wr_valid1;
  logic [1:0]  wr_sel0, wr_sel1;
  logic [28:0] wr_data0, wr_data1;
  logic        wr_ready0, wr_ready1;
  logic [57:0] sprites;
  logic [11:0] offset_x, offset_y;
  logic        update, pending, overwrite, sel_err;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  logic upd_seen;

  ppu_update_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .vblank    (vblank),
    .wr_valid0 (wr_valid0),
    .wr_sel0   (wr_sel0),
    .wr_data0  (wr_data0),
    .wr_ready0 (wr_ready0),
    .wr_valid1 (wr_valid1),
    .wr_sel1   (wr_sel1),
    .wr_data1  (wr_data1),
    .wr_ready1 (wr_ready1),
    .sprites   (sprites),
    .offset_x  (offset_x),
    .offset_y  (offset_y),
    .update    (update),
    .pending   (pending),
    .overwrite (overwrite),
    .sel_err   (sel_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; vblank = 1'b0;
    wr_valid0 = 1'b0; wr_sel0 = 2'd0; wr_data0 = '0;
    wr_valid1 = 1'b0; wr_sel1 = 2'd0; wr_data1 = '0;
    tick(); tick();
    check("rst_sprites", sprites, 0);
    check("rst_offx", offset_x, 0);
    check("rst_offy", offset_y, 0);
    check("rst_update", update, 0);
    check("rst_pending", pending, 0);
    check("rst_overwrite", overwrite, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_frame", frame_cnt, 0);
    reset = 1'b0;

    // 1: reset asserted while in COMMIT
    wr_valid0 = 1'b1; wr_sel0 = 2'd0; wr_data0 = 29'h0AAAAAA;
    #1 check("t1_ready0", wr_ready0, 1);
    tick();
    wr_valid0 = 1'b0; vblank = 1'b1;
    tick();
    wr_valid1 = 1'b1; wr_sel1 = 2'd1; wr_data1 = 29'h55;
    #1 check("t1_commit_blocks", wr_ready1, 0);
    reset = 1'b1;
    tick();
    check("t1_sprites", sprites, 0);
    check("t1_update", update, 0);
    check("t1_pending", pending, 0);
    check("t1_frame", frame_cnt, 0);
    check("t1_idle_ready1", wr_ready1, 1);
    reset = 1'b0; wr_valid1 = 1'b0; vblank = 1'b0;
    tick();
    check("t1_no_update", update, 0);

    // 2: sprite0 write committed at vblank start
    wr_valid0 = 1'b1; wr_sel0 = 2'd0; wr_data0 = 29'h1ABCDEF;
    #1 check("t2_ready0", wr_ready0, 1);
    tick();
    wr_valid0 = 1'b0;
    check("t2_pending_set", pending, 1);
    vblank = 1'b1;
    tick();
    check("t2_n1_update", update, 0);
    check("t2_n1_pending", pending, 1);
    check("t2_frame", frame_cnt, 1);
    tick();
    check("t2_sprite0", sprites[57:29], 29'h1ABCDEF);
    check("t2_sprite1", sprites[28:0], 0);
    check("t2_update", update, 1);
    check("t2_pending_clr", pending, 0);
    tick();
    check("t2_update_pulse", update, 0);
    vblank = 1'b0;
    tick();

    // 4: offsets commit, sprites untouched
    wr_valid1 = 1'b1; wr_sel1 = 2'd2; wr_data1 = 29'h0345123;
    #1 check("t4_ready1", wr_ready1, 1);
    tick();
    wr_valid1 = 1'b0; vblank = 1'b1;
    tick(); tick();
    check("t4_offx", offset_x, 12'h123);
    check("t4_offy", offset_y, 12'h345);
    check("t4_sprites", sprites, {29'h1ABCDEF, 29'h0});
    check("t4_update", update, 1);
    vblank = 1'b0;
    tick();
    check("t4_update_pulse", update, 0);

    // 5: double write to sprite1
    wr_valid0 = 1'b1; wr_sel0 = 2'd1; wr_data0 = 29'h5;
    tick();
    check("t5_ow_first", overwrite, 0);
    wr_data0 = 29'h7;
    tick();
    wr_valid0 = 1'b0;
    check("t5_ow_second", overwrite, 1);
    vblank = 1'b1;
    tick();
    check("t5_ow_commit", overwrite, 1);
    tick();
    check("t5_ow_cleared", overwrite, 0);
    check("t5_sprite1", sprites[28:0], 29'h7);
    check("t5_sprite0", sprites[57:29], 29'h1ABCDEF);
    check("t5_update", update, 1);
    vblank = 1'b0;
    tick();
    check("t5_frame", frame_cnt, 3);

    // 3: round-robin alternation from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    wr_valid0 = 1'b1; wr_sel0 = 2'd0; wr_data0 = 29'h11;
    wr_valid1 = 1'b1; wr_sel1 = 2'd1; wr_data1 = 29'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_ready0_%0d", i), wr_ready0, (i % 2 == 0));
      check($sformatf("t3_ready1_%0d", i), wr_ready1, (i % 2 == 1));
      tick();
    end
    wr_valid0 = 1'b0; wr_valid1 = 1'b0;
    check("t3_overwrite", overwrite, 1);
    check("t3_pending", pending, 1);

    // 6: empty frames, counter wrap, reserved select, boundary commits
    reset = 1'b1; tick(); reset = 1'b0;
    vblank = 1'b1;
    tick();
    check("t6_frame1", frame_cnt, 1);
    check("t6_no_update", update, 0);
    vblank = 1'b0;
    tick();
    check("t6_no_update2", update, 0);
    upd_seen = 1'b0;
    for (int i = 0; i < 255; i++) begin
      vblank = 1'b1; tick(); upd_seen |= update;
      vblank = 1'b0; tick(); upd_seen |= update;
    end
    check("t6_no_update_loop", upd_seen, 0);
    check("t6_frame_wrap", frame_cnt, 0);

    wr_valid0 = 1'b1; wr_sel0 = 2'd3; wr_data0 = 29'h1FFFFFFF;
    #1 check("t6_rsvd_ready", wr_ready0, 1);
    tick();
    wr_valid0 = 1'b0;
    check("t6_sel_err", sel_err, 1);
    check("t6_rsvd_pending", pending, 0);

    wr_valid1 = 1'b1; wr_sel1 = 2'd0; wr_data1 = 29'h0ABCDEF; vblank = 1'b1;
    #1 check("t6_same_cycle_ready", wr_ready1, 1);
    tick();
    wr_valid1 = 1'b0;
    check("t6_same_cycle_pending", pending, 1);
    tick();
    check("t6_same_cycle_update", update, 1);
    check("t6_same_cycle_sprite0", sprites[57:29], 29'h0ABCDEF);
    check("t6_sel_err_sticky", sel_err, 1);
    vblank = 1'b0;
    tick();

    wr_valid0 = 1'b1; wr_sel0 = 2'd1; wr_data0 = 29'h3;
    tick();
    wr_valid0 = 1'b0; vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    check("t6_drop_in_commit_update", update, 1);
    check("t6_drop_in_commit_sprite1", sprites[28:0], 29'h3);
    vblank = 1'b1; wr_valid0 = 1'b1; wr_sel0 = 2'd1; wr_data0 = 29'h4;
    #1 check("t6_hold_ready", wr_ready0, 1);
    tick();
    wr_valid0 = 1'b0;
    check("t6_glitch_update", update, 0);
    check("t6_glitch_pending", pending, 1);
    check("t6_glitch_frame", frame_cnt, 3);
    check("t6_glitch_sprite1", sprites[28:0], 29'h3);
    tick();
    check("t6_glitch_no_commit", update, 0);
    vblank = 1'b0;
    tick();
    check("t6_idle_update", update, 0);
    check("t6_idle_pending", pending, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
